// File: rtl/demux_1ton_buf.sv
// demux_1ton_buf: 1-to-NUM_PORTS flit demultiplexer with a DEPTH-entry FIFO per
// output port. It has valid/ready handshakes on both sides and back-pressures the
// input when the selected port's FIFO is full. A flit with a select of
// NUM_PORTS or above is dropped and raises the sticky err_sel_o flag.
// Optional feature: define DEMUX_1TON_STATS_EN to add the flit_cnt_o port, which
// holds per-port saturating counters of delivered (popped) flits.
module demux_1ton_buf #(
    parameter int   DATA_W    = 16,
    parameter int   NUM_PORTS = 5,
    parameter int   DEPTH     = 2,
    localparam int  SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic [SEL_W-1:0]              sel_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [NUM_PORTS*DATA_W-1:0]   data_o,
    output logic [NUM_PORTS-1:0]          valid_o,
    input  logic [NUM_PORTS-1:0]          ready_i,
    output logic                          err_sel_o,
    input  logic                          err_clr_i
`ifdef DEMUX_1TON_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]       flit_cnt_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic                 sel_legal;
    logic                 accept;

    assign sel_legal = (int'(sel_i) < NUM_PORTS);

    // Input-side ready: an illegal select is always accepted and then dropped;
    // a legal one waits for room. Only registered FIFO state feeds this, so
    // there is no path from ready_i to ready_o.
    always_comb begin
        // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
        ready_o = 1'b1;
        if (sel_legal) begin
            ready_o = !full[sel_i];
        end
    end

    assign accept = valid_i && ready_o;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [DATA_W-1:0] mem [DEPTH];

        assign push[p]  = accept && sel_legal && (int'(sel_i) == p);
        assign pop[p]   = !empty[p] && ready_i[p];
        assign full[p]  = (count == FULL_CNT);
        assign empty[p] = (count == '0);

        // FIFO storage, pointers and occupancy. A push and a pop in the same
        // cycle advance both pointers and leave the count unchanged.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                // NOTE: storage is reset on purpose so data_o is never X after reset; otherwise a RAM-style array would be left unreset.
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                // NOTE: non-blocking assignments make every register in this block update from pre-edge values.
                if (push[p]) begin
                    mem[wr_ptr] <= data_i;
                    wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
                end
                if (push[p] && !pop[p]) begin
                    count <= count + CNT_W'(1);
                end else if (!push[p] && pop[p]) begin
                    count <= count - CNT_W'(1);
                end
            end
        end

        assign valid_o[p]                   = !empty[p];
        assign data_o[p*DATA_W +: DATA_W]   = mem[rd_ptr];

`ifdef DEMUX_1TON_STATS_EN
        logic [15:0] flit_cnt;

        // Count delivered flits on this port and saturate at all-ones.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                flit_cnt <= '0;
            end else if (pop[p] && (flit_cnt != 16'hFFFF)) begin
                flit_cnt <= flit_cnt + 16'd1;
            end
        end

        assign flit_cnt_o[p*16 +: 16] = flit_cnt;
`endif
    end

    // Sticky illegal-select flag. Setting it wins over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_sel_o <= 1'b0;
        end else if (accept && !sel_legal) begin
            err_sel_o <= 1'b1;
        end else if (err_clr_i) begin
            err_sel_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_1ton_buf.sv
// Testbench for demux_1ton_buf with the default parameters (DATA_W=16, NUM_PORTS=5, DEPTH=2).
// A vector table covers basic routing; hand-written sequences cover back-pressure,
// head-of-line isolation, the error flag, asynchronous reset and the optional counters.
module tb_demux_1ton_buf;

    localparam int DATA_W    = 16;
    localparam int NUM_PORTS = 5;

    logic                        clk;
    logic                        rst_n;
    logic [DATA_W-1:0]           data_i;
    logic [2:0]                  sel_i;
    logic                        valid_i;
    logic                        ready_o;
    logic [NUM_PORTS*DATA_W-1:0] data_o;
    logic [NUM_PORTS-1:0]        valid_o;
    logic [NUM_PORTS-1:0]        ready_i;
    logic                        err_sel_o;
    logic                        err_clr_i;
`ifdef DEMUX_1TON_STATS_EN
    logic [NUM_PORTS*16-1:0]     flit_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    demux_1ton_buf #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .DEPTH(2)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .data_i     (data_i),
        .sel_i      (sel_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .err_sel_o  (err_sel_o),
        .err_clr_i  (err_clr_i)
`ifdef DEMUX_1TON_STATS_EN
        ,
        .flit_cnt_o (flit_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
        logic [4:0]  rdy;
        logic        exp_ready;
        logic [4:0]  exp_valid;
        logic [15:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] port_data(input int p);
        return data_o[p*DATA_W +: DATA_W];
    endfunction

    // Advance one clock; afterwards we sit 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        rst_n     = 1'b1;
        data_i    = '0;
        sel_i     = '0;
        valid_i   = 1'b0;
        ready_i   = 5'h1F;
        err_clr_i = 1'b0;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        #1;
        check("reset valid_o", 128'(valid_o), 128'(5'h00));
        check("reset data_o", 128'(data_o), 128'(80'h0));
        check("reset err_sel_o", 128'(err_sel_o), 128'(1'b0));
        check("reset ready_o", 128'(ready_o), 128'(1'b1));
`ifdef DEMUX_1TON_STATS_EN
        check("reset flit_cnt_o", 128'(flit_cnt_o), 128'(80'h0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- basic routing table ----------------
        vecs[0] = '{3'd0, 16'h1111, 5'h1F, 1'b1, 5'b00001, 16'h1111};
        vecs[1] = '{3'd1, 16'h2222, 5'h1F, 1'b1, 5'b00010, 16'h2222};
        vecs[2] = '{3'd2, 16'h3333, 5'h1F, 1'b1, 5'b00100, 16'h3333};
        vecs[3] = '{3'd3, 16'h4444, 5'h1F, 1'b1, 5'b01000, 16'h4444};
        vecs[4] = '{3'd4, 16'h5555, 5'h1F, 1'b1, 5'b10000, 16'h5555};
        vecs[5] = '{3'd6, 16'hDEAD, 5'h1F, 1'b1, 5'b00000, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            sel_i   = vecs[i].sel;
            data_i  = vecs[i].data;
            ready_i = vecs[i].rdy;
            valid_i = 1'b1;
            #1;
            check($sformatf("vec%0d ready_o", i), 128'(ready_o), 128'(vecs[i].exp_ready));
            step();
            check($sformatf("vec%0d valid_o", i), 128'(valid_o), 128'(vecs[i].exp_valid));
            if (vecs[i].exp_valid != 5'b0) begin
                check($sformatf("vec%0d data", i), 128'(port_data(int'(vecs[i].sel))), 128'(vecs[i].exp_data));
            end
        end
        valid_i = 1'b0;

        // ---------------- illegal select / err_sel_o ----------------
        check("err set after illegal sel", 128'(err_sel_o), 128'(1'b1));
        valid_i   = 1'b1;
        sel_i     = 3'd7;
        err_clr_i = 1'b1;
        step();
        check("err set beats clear", 128'(err_sel_o), 128'(1'b1));
        check("illegal sel no valid", 128'(valid_o), 128'(5'h00));
        valid_i = 1'b0;
        step();
        check("err cleared", 128'(err_sel_o), 128'(1'b0));
        err_clr_i = 1'b0;

        // ---------------- back-pressure on port 2 ----------------
        ready_i = 5'b11011;
        sel_i   = 3'd2;
        valid_i = 1'b1;
        data_i  = 16'hAAAA;
        #1 check("bp A ready", 128'(ready_o), 128'(1'b1));
        step();
        check("bp A valid", 128'(valid_o), 128'(5'b00100));
        data_i = 16'hBBBB;
        #1 check("bp B ready", 128'(ready_o), 128'(1'b1));
        step();
        data_i = 16'hCCCC;
        #1 check("bp C ready (full)", 128'(ready_o), 128'(1'b0));
        step();
        check("bp head still A", 128'(port_data(2)), 128'(16'hAAAA));
        ready_i = 5'h1F;
        #1 check("bp no ready_i->ready_o path", 128'(ready_o), 128'(1'b0));
        step();
        check("bp pop A -> head B", 128'(port_data(2)), 128'(16'hBBBB));
        check("bp ready after pop", 128'(ready_o), 128'(1'b1));
        step();
        check("bp head C", 128'(port_data(2)), 128'(16'hCCCC));
        check("bp C valid", 128'(valid_o), 128'(5'b00100));
        valid_i = 1'b0;
        step();
        check("bp drained", 128'(valid_o), 128'(5'b00000));

        // ---------------- head-of-line isolation ----------------
        ready_i = 5'b11110;
        sel_i   = 3'd0;
        valid_i = 1'b1;
        data_i  = 16'h0A0A;
        step();
        data_i = 16'h0B0B;
        step();
        #1 check("hol port0 full", 128'(ready_o), 128'(1'b0));
        sel_i  = 3'd3;
        data_i = 16'hD00D;
        #1 check("hol sel3 ready", 128'(ready_o), 128'(1'b1));
        step();
        check("hol valid", 128'(valid_o), 128'(5'b01001));
        check("hol port3 data", 128'(port_data(3)), 128'(16'hD00D));
        check("hol port0 head", 128'(port_data(0)), 128'(16'h0A0A));

        // ---------------- asynchronous reset mid-traffic ----------------
        ready_i = 5'b11100;
        sel_i   = 3'd1;
        data_i  = 16'h1234;
        step();
        valid_i = 1'b0;
        check("pre-reset valid", 128'(valid_o), 128'(5'b00011));
        #2 rst_n = 1'b0;
        #1;
        check("async reset valid_o", 128'(valid_o), 128'(5'h00));
        check("async reset data_o", 128'(data_o), 128'(80'h0));
        sel_i = 3'd0;
        #1 check("reset ready_o", 128'(ready_o), 128'(1'b1));
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 5'h1F;
        step();
        check("post-reset idle", 128'(valid_o), 128'(5'h00));
        sel_i   = 3'd4;
        data_i  = 16'h7777;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("post-reset route valid", 128'(valid_o), 128'(5'b10000));
        check("post-reset route data", 128'(port_data(4)), 128'(16'h7777));
        step();
        check("post-reset pop", 128'(valid_o), 128'(5'h00));

`ifdef DEMUX_1TON_STATS_EN
        // ---------------- counter saturation on port 4 ----------------
        check("cnt after one pop", 128'(flit_cnt_o), 128'({16'd1, 64'h0}));
        sel_i   = 3'd4;
        valid_i = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            data_i = 16'(i);
            step();
        end
        valid_i = 1'b0;
        step();
        step();
        check("cnt saturated", 128'(flit_cnt_o), 128'({16'hFFFF, 64'h0}));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
